// File: rtl/tanh_inverse_search_4bit_pkg.sv
// Shared types and helpers for the 4-bit tanh inverse search.
package tanh_inv_pkg;

    localparam int unsigned W          = 4;
    localparam int unsigned SWEEP_LAST = (1 << W) - 1;

    typedef logic [W-1:0] code_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    function automatic code_t abs_diff(input code_t a, input code_t b);
        return (a > b) ? code_t'(a - b) : code_t'(b - a);
    endfunction

endpackage

// File: rtl/tanh_inverse_search_4bit_if.sv
// Target-in / result-out handshake bundle for the tanh inverse search.
interface tanh_inv_if;
    import tanh_inv_pkg::*;

    logic  in_valid;
    logic  in_ready;
    code_t in_y;
    logic  out_valid;
    logic  out_ready;
    code_t out_x;
    code_t out_y;
    code_t out_err;
    logic  out_hit;

    modport master (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_err, out_hit
    );

    modport slave (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_x, out_y, out_err, out_hit
    );

endinterface

// File: rtl/tanh_approx_fwd_4bit.sv
// Combinational 4-bit approximate tanh f(x); range is {0,3,4,11,12}.
module tanh_approx_fwd_4bit
    import tanh_inv_pkg::*;
(
    input  code_t x,
    output code_t y
);

    assign y = {x[1], ~x[0] & (x[1] | (x[3] & x[2])), x[0], x[0]};

endmodule

// File: rtl/tanh_inverse_search_4bit.sv
// Sweeps X = 0..15 through f and returns the smallest X with f(X) closest to Y.
// Define TANH_INV_EARLY_EXIT_EN to stop the sweep at the first exact match.
module tanh_inverse_search_4bit
    import tanh_inv_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic       clk,
    input  logic       rst,
    tanh_inv_if.slave  bus
);

    if (W != 4) begin : g_bad_width
        $error("tanh_inverse_search_4bit: W must be 4");
    end

    state_t state_q, state_d;
    code_t  cand_q, cand_d;
    code_t  best_x_q, best_x_d;
    code_t  best_err_q, best_err_d;
    code_t  y_q, y_d;

    code_t  f_cand;
    code_t  f_best;
    code_t  err_c;
    logic   done;

    tanh_approx_fwd_4bit u_fwd_cand (
        .x (cand_q),
        .y (f_cand)
    );

    tanh_approx_fwd_4bit u_fwd_best (
        .x (best_x_q),
        .y (f_best)
    );

    assign err_c = abs_diff(f_cand, y_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            best_x_q   <= '0;
            best_err_q <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            best_x_q   <= best_x_d;
            best_err_q <= best_err_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        best_x_d   = best_x_q;
        best_err_d = best_err_q;
        y_d        = y_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    y_d        = bus.in_y;
                    cand_d     = '0;
                    best_x_d   = '0;
                    best_err_d = '1;
                    state_d    = SWEEP;
                end
            end
            SWEEP: begin
                // Strict compare keeps the smallest X on ties.
                if (err_c < best_err_q) begin
                    best_x_d   = cand_q;
                    best_err_d = err_c;
                end
                if (cand_q == code_t'(SWEEP_LAST)) begin
                    state_d = DONE;
                end else begin
                    cand_d = code_t'(cand_q + 1'b1);
                end
`ifdef TANH_INV_EARLY_EXIT_EN
                if (err_c == '0) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done          = (state_q == DONE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = done;
    assign bus.out_x     = done ? best_x_q : '0;
    assign bus.out_y     = done ? f_best : '0;
    assign bus.out_err   = done ? best_err_q : '0;
    assign bus.out_hit   = done && (best_err_q == '0);

endmodule

// File: tb/tb_tanh_inverse_search_4bit.sv
// Self-checking bench for tanh_inverse_search_4bit: vector table, random model, corner sequences.
module tb_tanh_inverse_search_4bit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tanh_inv_if bus ();

    tanh_inverse_search_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cur_y = 0;

    // Forward transfer table taken directly from the function's published listing.
    int ftab [16] = '{0, 3, 12, 11, 0, 3, 12, 11, 0, 3, 12, 11, 4, 3, 12, 11};

    typedef struct {
        int y;
        int x;
        int err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (y=%0d): got %0d, wanted %0d", name, cur_y, act, exp);
        end
    endtask

    function automatic int exp_lat(input int x, input int err);
`ifdef TANH_INV_EARLY_EXIT_EN
        if (err == 0) return x + 1;
`endif
        return 16;
    endfunction

    task automatic ref_model(input int y, output int bx, output int berr);
        int e;
        bx   = 0;
        berr = 1000;
        for (int x = 0; x < 16; x++) begin
            e = (ftab[x] > y) ? ftab[x] - y : y - ftab[x];
            if (e < berr) begin
                berr = e;
                bx   = x;
            end
        end
    endtask

    task automatic run_one(input int y, input int ex_x, input int ex_err, input int hold);
        int n;
        int sx;
        int serr;
        cur_y = y;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) chk("idle_timeout", 1, 0);
        bus.in_y     = 4'(y);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, exp_lat(ex_x, ex_err));
        chk("out_x", int'(bus.out_x), ex_x);
        chk("out_y", int'(bus.out_y), ftab[ex_x]);
        chk("out_err", int'(bus.out_err), ex_err);
        chk("out_hit", int'(bus.out_hit), (ex_err == 0) ? 1 : 0);
        sx   = int'(bus.out_x);
        serr = int'(bus.out_err);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_y     = 4'(15 - y);
            @(posedge clk); #1;
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_x_stable", int'(bus.out_x), sx);
            chk("bp_err_stable", int'(bus.out_err), serr);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_in_ready", int'(bus.in_ready), 1);
        chk("post_out_valid", int'(bus.out_valid), 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chk({tag, "_out_x"}, int'(bus.out_x), 0);
        chk({tag, "_out_y"}, int'(bus.out_y), 0);
        chk({tag, "_out_err"}, int'(bus.out_err), 0);
        chk({tag, "_out_hit"}, int'(bus.out_hit), 0);
    endtask

    initial begin
        int rx;
        int rerr;
        int ry;

        vecs[0] = '{y: 11, x: 3,  err: 0};
        vecs[1] = '{y: 4,  x: 12, err: 0};
        vecs[2] = '{y: 0,  x: 0,  err: 0};
        vecs[3] = '{y: 7,  x: 12, err: 3};
        vecs[4] = '{y: 8,  x: 3,  err: 3};
        vecs[5] = '{y: 15, x: 2,  err: 3};
        vecs[6] = '{y: 12, x: 2,  err: 0};
        vecs[7] = '{y: 3,  x: 1,  err: 0};

        bus.in_valid  = 1'b0;
        bus.in_y      = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) run_one(vecs[i].y, vecs[i].x, vecs[i].err, 0);

        // Back-to-back Y=0: with early exit the next accept lands at T+3.
        run_one(0, 0, 0, 0);
        run_one(0, 0, 0, 0);

        // Backpressure with a competing in_valid held during DONE.
        run_one(7, 12, 3, 5);
        run_one(11, 3, 0, 0);

        for (int i = 0; i < 20; i++) begin
            ry = $urandom_range(0, 15);
            ref_model(ry, rx, rerr);
            run_one(ry, rx, rerr, $urandom_range(0, 2));
        end

        // Reset in the middle of a sweep discards the pending result.
        cur_y        = 15;
        bus.in_y     = 4'd15;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("sweep_busy", int'(bus.in_ready), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_outputs("midrst");
        run_one(12, 2, 0, 0);

        // Reset while a result is waiting in DONE.
        cur_y        = 8;
        bus.in_y     = 4'd8;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("done_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle_outputs("donerst");
        run_one(4, 12, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
